link_fifo_sync: RTL

Synthesizable single-clock FIFO for the IEEE1355 link datapath, buffering character/data words between the link receiver/transmitter and the host side. It is the parametrised successor to the testbench FIFO model. It adds full/empty and programmable almost-full/almost-empty flags, overflow/underflow protection with sticky error flags, and a selectable read mode: registered standard read or first-word-fall-through (FWFT).

---
 rtl/link_fifo_sync.sv | 105 ++++++++++
 1 files changed

// File: rtl/link_fifo_sync.sv
// Single-clock FIFO for the IEEE1355 link datapath: fill-level based flags,
// sticky overflow/underflow errors, and selectable standard or FWFT read.
module link_fifo_sync #(
    parameter int G_DATA_WIDTH_BITS = 8,
    parameter int G_ADDR_WIDTH_BITS = 6,
    parameter int G_FWFT            = 0,
    parameter int G_ALMOST_FULL     = 2**G_ADDR_WIDTH_BITS - 4,
    parameter int G_ALMOST_EMPTY    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic [G_DATA_WIDTH_BITS-1:0] w_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         r_en,
    output logic [G_DATA_WIDTH_BITS-1:0] r_data,
    output logic                         r_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [G_ADDR_WIDTH_BITS:0]   fill_level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clr
);
    localparam int DEPTH = 2**G_ADDR_WIDTH_BITS;
    localparam int LW    = G_ADDR_WIDTH_BITS + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(G_ALMOST_FULL);
    localparam logic [LW-1:0] LVL_AE   = LW'(G_ALMOST_EMPTY);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    if (G_ALMOST_FULL < 0 || G_ALMOST_FULL > DEPTH ||
        G_ALMOST_EMPTY < 0 || G_ALMOST_EMPTY > DEPTH) begin : g_bad_threshold
        $error("link_fifo_sync: almost_full/almost_empty threshold outside 0..DEPTH");
    end

    logic [G_DATA_WIDTH_BITS-1:0] mem [DEPTH];
    logic [G_ADDR_WIDTH_BITS-1:0] w_addr;
    logic [G_ADDR_WIDTH_BITS-1:0] r_addr;
    logic                         rd_ok;
    logic                         wr_ok;

    // Flags come only from the registered level; pointers are free-running.
    assign full         = (fill_level == LVL_FULL);
    assign empty        = (fill_level == '0);
    assign almost_full  = (fill_level >= LVL_AF);
    assign almost_empty = (fill_level <= LVL_AE);

    // A read frees a slot in the same edge, so a full FIFO still takes a write.
    assign rd_ok = r_en & ~empty;
    assign wr_ok = w_en & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok && !rst)
            mem[w_addr] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr     <= '0;
            r_addr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_ok)
                w_addr <= w_addr + 1'b1;
            if (rd_ok)
                r_addr <= r_addr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   fill_level <= fill_level + LVL_ONE;
                2'b01:   fill_level <= fill_level - LVL_ONE;
                default: fill_level <= fill_level;
            endcase
            // Set takes priority over a same-cycle clear.
            overflow  <= (overflow  & ~err_clr) | (w_en & ~wr_ok);
            underflow <= (underflow & ~err_clr) | (r_en & ~rd_ok);
        end
    end

    if (G_FWFT == 0) begin : g_std
        logic [G_DATA_WIDTH_BITS-1:0] rd_q;
        logic                         vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= rd_ok;
                if (rd_ok)
                    rd_q <= mem[r_addr];
            end
        end

        assign r_data  = rd_q;
        assign r_valid = vld_q;
    end else begin : g_fwft
        // Head word is presented directly; meaningless while empty.
        assign r_data  = mem[r_addr];
        assign r_valid = ~empty;
    end

endmodule
